// File: rtl/mixer_pkg.sv
// Shared types and width helpers for the gain mixers.
// Widths are functions so each mixer derives them from its own BITSIZE/GAINBITS.
package mixer_pkg;

    localparam int BITSIZE_DEF  = 16;
    localparam int GAINBITS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Signed sample times zero-extended gain (GAINBITS+1 signed bits).
    function automatic int prod_width(input int bitsize, input int gainbits);
        return bitsize + gainbits + 1;
    endfunction

    // Two guard bits hold the sum of four products without overflow.
    function automatic int acc_width(input int bitsize, input int gainbits);
        return bitsize + gainbits + 3;
    endfunction

    // 0.25 in Q1.(GAINBITS-1); matches the fixed quarter-sum mixer.
    function automatic int default_gain(input int gainbits);
        return 1 << (gainbits - 3);
    endfunction

    localparam int PROD_W_DEF       = prod_width(BITSIZE_DEF, GAINBITS_DEF);
    localparam int ACC_W_DEF        = acc_width(BITSIZE_DEF, GAINBITS_DEF);
    localparam int DEFAULT_GAIN_DEF = default_gain(GAINBITS_DEF);

endpackage

// File: rtl/mixer4_gain_sched_sat_shift.sv
// Arithmetic right shift (floor) followed by saturation to a narrower signed width.
// Purely combinational so any mixer can drop it after its accumulator.
module sat_shift #(
    parameter int IN_W  = 27,
    parameter int OUT_W = 16,
    parameter int SHIFT = 7
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    logic signed [IN_W-1:0]   shifted;
    logic        [IN_W-OUT_W:0] upper;

    assign shifted = din >>> SHIFT;
    // In range only when every bit from the output sign bit upward agrees.
    assign upper   = shifted[IN_W-1:OUT_W-1];

    // NOTE: dout gets a default before any branch so this always_comb cannot infer a latch.
    always_comb begin
        dout = shifted[OUT_W-1:0];
        if (!shifted[IN_W-1] && (|upper)) begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (shifted[IN_W-1] && !(&upper)) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/mixer4_gain_sched.sv
// Four-channel weighted mixer: latches a sample set on strobe, runs one shared
// multiplier over four cycles, then saturates and presents the mix with a valid pulse.
module mixer4_gain_sched
    import mixer_pkg::*;
#(
    parameter int BITSIZE  = BITSIZE_DEF,
    parameter int GAINBITS = GAINBITS_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_valid,
    input  logic signed [BITSIZE-1:0]  in1,
    input  logic signed [BITSIZE-1:0]  in2,
    input  logic signed [BITSIZE-1:0]  in3,
    input  logic signed [BITSIZE-1:0]  in4,
    input  logic                       cfg_we,
    input  logic [1:0]                 cfg_addr,
    input  logic [GAINBITS-1:0]        cfg_data,
    output logic signed [BITSIZE-1:0]  out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int PROD_W = prod_width(BITSIZE, GAINBITS);
    localparam int ACC_W  = acc_width(BITSIZE, GAINBITS);
    localparam logic [GAINBITS-1:0] GAIN_RST = GAINBITS'(default_gain(GAINBITS));

    state_t                     state, state_next;
    logic [1:0]                 ch;
    logic signed [BITSIZE-1:0]  samp   [4];
    logic [GAINBITS-1:0]        shadow [4];
    logic [GAINBITS-1:0]        active [4];
    logic signed [ACC_W-1:0]    acc;
    logic signed [PROD_W-1:0]   prod;
    logic signed [BITSIZE-1:0]  sat_out;
    logic                       accept;

    assign accept = (state == IDLE) && sample_valid;
    assign busy   = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sample_valid) state_next = MAC;
            MAC:     if (ch == 2'd3)   state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // The one multiplier in the design; the channel mux on ch feeds both operands.
    assign prod = samp[ch] * $signed({1'b0, active[ch]});

    sat_shift #(
        .IN_W  (ACC_W),
        .OUT_W (BITSIZE),
        .SHIFT (GAINBITS-1)
    ) u_sat (
        .din  (acc),
        .dout (sat_out)
    );

    // NOTE: the gain banks and sample latches are reset explicitly; they are a few flops, not a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                samp[i]   <= '0;
                shadow[i] <= GAIN_RST;
                active[i] <= GAIN_RST;
            end
            acc       <= '0;
            ch        <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            overrun   <= sample_valid && busy;

            // Active gains take the pre-write shadow, so a same-edge write lands next frame.
            if (accept) begin
                samp[0] <= in1;
                samp[1] <= in2;
                samp[2] <= in3;
                samp[3] <= in4;
                for (int i = 0; i < 4; i++) active[i] <= shadow[i];
                acc <= '0;
                ch  <= '0;
            end
            if (cfg_we) shadow[cfg_addr] <= cfg_data;

            if (state == MAC) begin
                acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                ch  <= ch + 2'd1;
            end
            if (state == OUT) begin
                out       <= sat_out;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mixer4_gain_sched.sv
// Self-checking bench for mixer4_gain_sched: a frame-level reference model tracks
// accepted strobes by cycle distance and is compared with the DUT every cycle.
module tb_mixer4_gain_sched;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               sample_valid = 1'b0;
    logic signed [15:0] in1 = '0, in2 = '0, in3 = '0, in4 = '0;
    logic               cfg_we = 1'b0;
    logic [1:0]         cfg_addr = '0;
    logic [7:0]         cfg_data = '0;
    logic signed [15:0] dout;
    logic               out_valid, busy, overrun;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    mixer4_gain_sched #(.BITSIZE(16), .GAINBITS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .in1          (in1),
        .in2          (in2),
        .in3          (in3),
        .in4          (in4),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .out          (dout),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Weighted sum, floor divide by unity gain (128), clamp to 16-bit signed.
    function automatic int model_mix(input int s0, s1, s2, s3, g0, g1, g2, g3);
        longint sum;
        longint q;
        sum = longint'(s0) * g0 + longint'(s1) * g1 + longint'(s2) * g2 + longint'(s3) * g3;
        q = sum >>> 7;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return int'(q);
    endfunction

    // ---------------- reference model ----------------
    int                 m_shadow [4];
    longint             k = 0;
    longint             fs = 0;
    bit                 m_have = 1'b0;
    int                 m_result = 0;
    logic signed [15:0] exp_out;
    logic               exp_valid, exp_busy, exp_overrun;

    always @(posedge clk or posedge rst) begin : model
        longint d;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_shadow[i] <= 32;
            m_have      <= 1'b0;
            exp_out     <= '0;
            exp_valid   <= 1'b0;
            exp_busy    <= 1'b0;
            exp_overrun <= 1'b0;
        end else begin
            d = m_have ? (k - fs) : 1000;
            exp_overrun <= 1'b0;
            if (sample_valid) begin
                if (d >= 1 && d <= 5) begin
                    exp_overrun <= 1'b1;
                end else begin
                    fs       <= k;
                    m_have   <= 1'b1;
                    m_result <= model_mix(int'(in1), int'(in2), int'(in3), int'(in4),
                                          m_shadow[0], m_shadow[1], m_shadow[2], m_shadow[3]);
                    d = 0;
                end
            end
            if (cfg_we) m_shadow[cfg_addr] <= int'(cfg_data);
            exp_valid <= (d == 5);
            if (d == 5) exp_out <= 16'(m_result);
            exp_busy <= (d >= 0 && d <= 4);
            k <= k + 1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("out", dout, exp_out);
            check("out_valid", out_valid, exp_valid);
            check("busy", busy, exp_busy);
            check("overrun", overrun, exp_overrun);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        cfg_we       = 1'b0;
    endtask

    task automatic set_gain(input int a, input int g);
        cfg_addr = 2'(a);
        cfg_data = 8'(g);
        cfg_we   = 1'b1;
        step();
    endtask

    task automatic set_all(input int g);
        for (int i = 0; i < 4; i++) set_gain(i, g);
    endtask

    task automatic strobe(input int a, input int b, input int c, input int d);
        in1 = 16'(a); in2 = 16'(b); in3 = 16'(c); in4 = 16'(d);
        sample_valid = 1'b1;
        step();
    endtask

    // Waits (bounded) for out_valid after a strobe; checks latency, busy span and value.
    task automatic wait_frame(input string name, input int exp_val);
        bit seen = 1'b0;
        int busy_n = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (out_valid) begin
                seen = 1'b1;
                check({name, "_latency"}, i - 1, 5);
                check({name, "_busy_cycles"}, busy_n, 5);
                check(name, dout, exp_val);
            end
        end
        check({name, "_seen"}, seen, 1);
    endtask

    initial begin
        // Pin the model to hand-computed values.
        check("model_default", model_mix(4000, 8000, -4000, 12000, 32, 32, 32, 32), 5000);
        check("model_sat_hi", model_mix(32767, 32767, 32767, 32767, 255, 255, 255, 255), 32767);
        check("model_floor", model_mix(-1, 0, 0, 0, 1, 0, 0, 0), -1);

        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cmp_en = 1'b1;
        check("rst_out", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_overrun", overrun, 0);
        step();

        // Default quarter gains.
        strobe(4000, 8000, -4000, 12000);
        wait_frame("default_mix", 5000);

        // Saturation on both rails.
        set_all(255);
        strobe(32767, 32767, 32767, 32767);
        wait_frame("sat_hi", 32767);
        strobe(-32768, -32768, -32768, -32768);
        wait_frame("sat_lo", -32768);

        // Unity on channel 0 only, then floor rounding of -1/128.
        set_gain(0, 128); set_gain(1, 0); set_gain(2, 0); set_gain(3, 0);
        strobe(-12345, 1000, 1000, 1000);
        wait_frame("unity_ch0", -12345);
        set_gain(0, 1);
        strobe(-1, 0, 0, 0);
        wait_frame("floor_shift", -1);

        // Second strobe 3 clocks after the first is dropped.
        begin
            int n_valid = 0, n_over = 0;
            logic signed [15:0] got = '0;
            set_all(64);
            strobe(1000, 2000, 3000, 4000);
            step(); step();
            in1 = 16'sd7; in2 = 16'sd7; in3 = 16'sd7; in4 = 16'sd7;
            sample_valid = 1'b1;
            step();
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (out_valid) begin n_valid++; got = dout; end
                if (overrun) n_over++;
            end
            check("overrun_valid_count", n_valid, 1);
            check("overrun_pulse_count", n_over, 1);
            check("overrun_first_frame", got, 5000);
        end

        // Gain write on the accepting edge lands in the next frame.
        set_all(32);
        in1 = 16'sd1000; in2 = '0; in3 = '0; in4 = '0;
        cfg_addr = 2'd0; cfg_data = 8'd128; cfg_we = 1'b1;
        sample_valid = 1'b1;
        step();
        wait_frame("cfg_same_edge_old", 250);
        strobe(1000, 0, 0, 0);
        wait_frame("cfg_same_edge_new", 1000);

        // Reset in the middle of a frame.
        begin
            int n_valid = 0;
            set_all(200);
            strobe(4000, 8000, -4000, 12000);
            step();
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            check("midrst_out", dout, 0);
            check("midrst_busy", busy, 0);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (out_valid) n_valid++;
            end
            check("midrst_no_valid", n_valid, 0);
            strobe(4000, 8000, -4000, 12000);
            wait_frame("post_rst_default", 5000);
        end

        // Randomized traffic; the compare process checks every cycle.
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 6) == 0) begin
                cfg_we   = 1'b1;
                cfg_addr = 2'($urandom_range(0, 3));
                cfg_data = 8'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                sample_valid = 1'b1;
                if ($urandom_range(0, 7) == 0) begin
                    in1 = 16'sh7fff; in2 = 16'sh7fff; in3 = 16'sh8000; in4 = 16'(32'($urandom));
                end else begin
                    in1 = 16'($urandom); in2 = 16'($urandom);
                    in3 = 16'($urandom); in4 = 16'($urandom);
                end
            end
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
            end
            step();
        end

        repeat (10) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
